// File: rtl/flappy_game_ctrl.sv
// Game sequencer for the pipe scroller: start/lose FSM, scroll prescaler, score latch.
// Define HIGH_SCORE_EN to keep a best-score register; otherwise high_score is tied to zero.
module flappy_game_ctrl #(
  parameter int SCROLL_DIV  = 250000,
  parameter int DIV_W       = 18,
  parameter int DEATH_TICKS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       lose,
  input  logic [3:0] score_in,
  output logic       pipe_reset,
  output logic       count_EN,
  output logic       tick,
  output logic [1:0] state_out,
  output logic       game_over,
  output logic [3:0] final_score,
  output logic [3:0] high_score
);

  localparam int HOLD_W = $clog2(DEATH_TICKS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCROLL_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(DEATH_TICKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic              btn_p0, btn_p1, btn_p2;
  logic              start_pulse;
  logic              lose_evt;

  // Button synchroniser (p0/p1) plus previous-value stage (p2) for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_p0      <= 1'b0;
      btn_p1      <= 1'b0;
      btn_p2      <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      btn_p0      <= start_btn;
      btn_p1      <= btn_p0;
      btn_p2      <= btn_p1;
      start_pulse <= btn_p1 & ~btn_p2;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    lose_evt  = 1'b0;
    case (state)
      IDLE: if (start_pulse) state_nxt = LOAD;
      LOAD: state_nxt = PLAY;
      PLAY: begin
        if (lose) begin
          state_nxt = OVER;
          hold_nxt  = HOLD_INIT;
          lose_evt  = 1'b1;
        end
      end
      OVER: begin
        if (tick && hold != '0) hold_nxt = hold - HOLD_W'(1);
        // A press during the hold-off is dropped, not remembered
        if (start_pulse && hold == '0) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
    // Clearing on the LOAD->PLAY edge gives a full period before the first step
    if (state == LOAD || div_cnt == DIV_LAST) div_nxt = '0;
    else                                      div_nxt = div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      div_cnt     <= '0;
      hold        <= '0;
      tick        <= 1'b0;
      pipe_reset  <= 1'b1;
      final_score <= 4'd0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      hold       <= hold_nxt;
      tick       <= (div_nxt == DIV_LAST);
      pipe_reset <= (state_nxt == IDLE) || (state_nxt == LOAD);
      if (lose_evt) final_score <= score_in;
    end
  end

`ifdef HIGH_SCORE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               high_score <= 4'd0;
    else if (lose_evt && score_in > high_score) high_score <= score_in;
  end
`else
  assign high_score = 4'd0;
`endif

  // Collision in the same cycle as a tick must not step the scroller
  assign count_EN  = (state == PLAY) && tick && !lose;
  assign state_out = state;
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl with SCROLL_DIV=4, DEATH_TICKS=3.
module tb_flappy_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic       lose;
  logic [3:0] score_in;
  logic       pipe_reset;
  logic       count_EN;
  logic       tick;
  logic [1:0] state_out;
  logic       game_over;
  logic [3:0] final_score;
  logic [3:0] high_score;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef HIGH_SCORE_EN
  localparam bit HS_ON = 1'b1;
`else
  localparam bit HS_ON = 1'b0;
`endif

  flappy_game_ctrl #(.SCROLL_DIV(4), .DIV_W(3), .DEATH_TICKS(3)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .lose(lose),
    .score_in(score_in), .pipe_reset(pipe_reset), .count_EN(count_EN),
    .tick(tick), .state_out(state_out), .game_over(game_over),
    .final_score(final_score), .high_score(high_score)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int         reps;
    logic       start;
    logic       lose;
    logic [3:0] score;
    logic [1:0] st;
    logic       pr;
    logic       en;
    logic       tk;
    logic       go;
    logic [3:0] fs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int reps, input logic s, input logic l, input logic [3:0] sc,
                     input logic [1:0] st, input logic pr, input logic en,
                     input logic tk, input logic go, input logic [3:0] fs);
    vec_t v;
    v.reps = reps; v.start = s; v.lose = l; v.score = sc; v.st = st;
    v.pr = pr; v.en = en; v.tk = tk; v.go = go; v.fs = fs;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] target, input int max);
    int n = 0;
    while (state_out !== target && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state", int'(state_out), int'(target));
  endtask

  task automatic play_round(input logic [3:0] sc, input logic [3:0] exp_hs);
    start_btn = 1'b1;
    wait_state(2'd2, 20);
    start_btn = 1'b0;
    score_in  = sc;
    lose      = 1'b1;
    @(negedge clk);
    lose = 1'b0;
    chk("round_state", int'(state_out), 3);
    chk("round_final_score", int'(final_score), int'(sc));
    chk("round_high_score", int'(high_score), int'(exp_hs));
    repeat (20) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start_btn = 1'b0; lose = 1'b0; score_in = 4'd5;

    // Cycle table: start, lose, score | state, pipe_reset, count_EN, tick, game_over, final_score
    add(2, 0,0,5, 0,1,0,0,0,0);
    add(1, 0,0,5, 0,1,0,1,0,0);
    add(3, 0,0,5, 0,1,0,0,0,0);
    add(1, 0,0,5, 0,1,0,1,0,0);
    add(3, 0,1,5, 0,1,0,0,0,0);
    add(1, 0,0,5, 0,1,0,1,0,0);
    add(3, 0,0,5, 0,1,0,0,0,0);
    add(1, 0,0,5, 0,1,0,1,0,0);
    add(3, 0,0,5, 0,1,0,0,0,0);
    add(1, 0,0,5, 0,1,0,1,0,0);
    add(1, 0,0,5, 0,1,0,0,0,0);
    add(2, 1,0,5, 0,1,0,0,0,0);
    add(1, 1,0,5, 0,1,0,1,0,0);
    add(1, 1,0,5, 0,1,0,0,0,0);
    add(1, 1,1,5, 1,1,0,0,0,0);
    add(3, 1,0,5, 2,0,0,0,0,0);
    add(1, 1,0,5, 2,0,1,1,0,0);
    add(1, 1,0,5, 2,0,0,0,0,0);
    add(2, 0,0,5, 2,0,0,0,0,0);
    add(1, 0,1,5, 2,0,0,1,0,0);
    add(1, 0,1,9, 3,0,0,0,1,5);
    add(2, 0,0,9, 3,0,0,0,1,5);
    add(1, 0,0,9, 3,0,0,1,1,5);
    add(2, 1,0,9, 3,0,0,0,1,5);
    add(1, 0,0,9, 3,0,0,0,1,5);
    add(1, 0,0,9, 3,0,0,1,1,5);
    add(3, 0,0,9, 3,0,0,0,1,5);
    add(1, 0,0,9, 3,0,0,1,1,5);
    add(1, 0,0,9, 3,0,0,0,1,5);
    add(2, 1,0,9, 3,0,0,0,1,5);
    add(1, 0,0,9, 3,0,0,1,1,5);
    add(1, 0,0,9, 3,0,0,0,1,5);
    add(1, 0,0,9, 1,1,0,0,0,5);
    add(3, 0,0,9, 2,0,0,0,0,5);
    add(1, 0,0,9, 2,0,1,1,0,5);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state_out), 0);
    chk("rst_pipe_reset", int'(pipe_reset), 1);
    chk("rst_count_EN", int'(count_EN), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_final_score", int'(final_score), 0);
    chk("rst_high_score", int'(high_score), 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        @(posedge clk);
        #1;
        start_btn = tbl[i].start;
        lose      = tbl[i].lose;
        score_in  = tbl[i].score;
        @(negedge clk);
        cyc++;
        chk("state_out", int'(state_out), int'(tbl[i].st));
        chk("pipe_reset", int'(pipe_reset), int'(tbl[i].pr));
        chk("count_EN", int'(count_EN), int'(tbl[i].en));
        chk("tick", int'(tick), int'(tbl[i].tk));
        chk("game_over", int'(game_over), int'(tbl[i].go));
        chk("final_score", int'(final_score), int'(tbl[i].fs));
      end
    end

    // Asynchronous reset in the middle of a PLAY cycle
    #2;
    reset = 1'b0;
    #1;
    chk("async_state", int'(state_out), 0);
    chk("async_pipe_reset", int'(pipe_reset), 1);
    chk("async_count_EN", int'(count_EN), 0);
    chk("async_final_score", int'(final_score), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_after_reset", int'(state_out), 0);
    chk("idle_pipe_reset", int'(pipe_reset), 1);

    play_round(4'd7, HS_ON ? 4'd7 : 4'd0);
    play_round(4'd4, HS_ON ? 4'd7 : 4'd0);
    play_round(4'd9, HS_ON ? 4'd9 : 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
Top-level gameplay sequencer for the pipe scroller. Turns the start button and the obstacle-logic lose flag into a 4-state game FSM. Drives the scroller's active-high synchronous reset and its one-cycle scroll enable from an internal prescaler. Latches the final score when the player loses.

Parameters:
SCROLL_DIV, 250000, clk cycles per scroll tick (25 MHz / 100 Hz); must be >= 2
DIV_W, 18, prescaler counter width; 2^DIV_W must be >= SCROLL_DIV
DEATH_TICKS, 100, scroll ticks in OVER during which start is ignored; must be >= 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_btn  in  1  raw start button, asynchronous to clk
lose  in  1  collision flag from obstacle logic, synchronous
score_in  in  4  live score from the pipe scroller
pipe_reset  out  1  active-high synchronous reset to the pipe scroller
count_EN  out  1  one-cycle scroll-step enable to the pipe scroller
tick  out  1  raw prescaler tick, one cycle, free-running in all states
state_out  out  2  IDLE=0, LOAD=1, PLAY=2, OVER=3
game_over  out  1  high while in OVER
final_score  out  4  score latched at the lose event
high_score  out  4  best final score (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-low, all flops. While reset=0: state=IDLE, pipe_reset=1, count_EN=0, tick=0, game_over=0, final_score=0, high_score=0, prescaler=0, hold-off=0, synchroniser=0.
- start_btn passes through a 2-FF synchroniser followed by a rising-edge detect.
- The edge detect produces start_pulse, asserted one cycle at clk edge 3 after start_btn rises.
- A held button produces exactly one start_pulse.
- Prescaler counts 0..SCROLL_DIV-1 and wraps to 0.
- tick=1 for the one cycle in which the count equals SCROLL_DIV-1.
- In LOAD the prescaler is forced to 0, so the first PLAY tick occurs exactly SCROLL_DIV cycles after entering PLAY.
- All outputs are registered, except count_EN, state_out and game_over, which are decoded from state and are glitch-free.
- IDLE:
  - pipe_reset=1, count_EN=0.
  - start_pulse moves to LOAD.
- LOAD (one cycle):
  - pipe_reset=1, count_EN=0, prescaler cleared.
  - Unconditionally moves to PLAY.
- PLAY:
  - pipe_reset=0; count_EN=tick.
  - start_pulse is ignored.
  - lose=1 sampled at an edge moves to OVER on that edge. On the same edge, final_score<=score_in and hold-off<=DEATH_TICKS.
  - count_EN=0 in any cycle where lose=1, even if tick=1. The scroller never steps after a collision.
- OVER:
  - pipe_reset=0 (frozen pipes stay visible), count_EN=0, game_over=1.
  - hold-off decrements by 1 on each tick while nonzero.
  - start_pulse while hold-off!=0 is discarded; it is not queued.
  - start_pulse while hold-off==0 moves to LOAD. final_score is held until the next lose.
- lose is ignored in IDLE, LOAD and OVER.
- An asynchronous reset asserted mid-game returns to IDLE immediately. pipe_reset rises asynchronously with it.
- final_score and high_score are 4-bit. A score wrap from 15 to 0 is the scroller's behaviour and is passed through unmodified.

Optional Feature:
HIGH_SCORE_EN.
- Defined: on the PLAY->OVER edge, high_score<=score_in if score_in>high_score, else it is held. It is cleared only by reset and survives LOAD/IDLE.
- Undefined: high_score is tied to 4'd0 and no register is synthesised.

Test Plan:
1. SCROLL_DIV=4, DEATH_TICKS=3; release reset, hold start_btn=0 for 20 cycles -> state_out=0, pipe_reset=1, count_EN=0 throughout; tick pulses every 4 cycles.
2. Pulse start_btn (held 10 cycles) -> exactly one LOAD cycle (state_out=1) at edge 4; PLAY thereafter; first count_EN exactly 4 cycles after PLAY entry, then every 4 cycles; pipe_reset=0 in PLAY.
3. In PLAY with score_in=5, assert lose=1 in the same cycle as tick -> count_EN=0 that cycle; next cycle state_out=3, game_over=1, final_score=5.
4. In OVER, pulse start after 1 tick -> ignored, state stays 3. Pulse start after 3 ticks -> LOAD then PLAY; final_score still 5.
5. HIGH_SCORE_EN defined: lose with score 7, then 4, then 9 -> high_score 7, 7, 9. Undefined -> high_score=0 always.
6. Drive reset=0 mid-PLAY between clock edges -> state_out=0, pipe_reset=1, count_EN=0 immediately; after release, start required to play again.
